adc_scan_scheduler: RTL and testbench
=====================================

# adc_scan_scheduler

Sequencer that owns the single-channel ADS1115 conversion block and turns it into a multi-channel scanner. It walks the enabled channels of a 4-bit mask in ascending order, runs one single-shot conversion per channel through the ADC block's enable/ready handshake, and latches each result into a per-channel sample register. Scans start either on a software trigger or periodically from an internal tick. It sits between the control logic (register file / UART command layer) and the ADC + I2C pair.

## Interface
- SCAN_PERIOD, 27_000_000: clock cycles between scan ticks in continuous mode (≥ 2).
- TIMEOUT_CYCLES, 2_700_000: cycles to wait for one conversion before flagging timeout.
- clk_i  in  1  system clock (single clock domain).
- rst_ni  in  1  asynchronous, active-low reset.
- trigger_i  in  1  single-cycle request for one scan (ignored while busy).
- continuous_i  in  1  1 = periodic scans from the internal tick.
- channel_mask_i  in  4  bit n enables AINn; sampled at scan start.
- clear_i  in  1  clears the sticky overrun_o and timeout_o flags.
- adc_channel_o  out  2  channel select to the ADC block.
- adc_enable_o  out  1  conversion request to the ADC block.
- adc_data_i  in  16  conversion result from the ADC block.
- adc_data_ready_i  in  1  ADC done level; stale-high until the next request is accepted.
- sample_o  out  64  {ch3, ch2, ch1, ch0} latched results, 16 bits each.
- sample_valid_o  out  4  one-cycle strobe; bit n is high in the cycle after chn updates.
- busy_o  out  1  scan in progress.
- scan_done_o  out  1  one-cycle pulse after the last enabled channel is latched.
- overrun_o  out  1  sticky: a periodic tick arrived while busy.
- timeout_o  out  1  sticky: a conversion exceeded TIMEOUT_CYCLES.

## Operation
- States: IDLE, SELECT, WAIT_CLR, WAIT_RDY, RELEASE, DONE.
- Scan start:
  - In IDLE, a scan starts on `trigger_i`, or on a tick while `continuous_i`=1.
  - The scan latches `channel_mask_i` into a pending mask.
  - An all-zero mask starts nothing. There is no busy, no scan_done_o, and no overrun.
- SELECT:
  - Picks the lowest set bit of the pending mask and drives `adc_channel_o` to it.
  - Sets `adc_enable_o`=1, clears that pending bit, then goes to WAIT_CLR.
- WAIT_CLR:
  - Waits for `adc_data_ready_i`=0, which means the ADC has accepted the request.
  - Then goes to WAIT_RDY.
  - A stale ready level from the previous conversion must never be captured.
- WAIT_RDY: on `adc_data_ready_i`=1:
  - latch `adc_data_i` into the selected channel's slice of `sample_o`;
  - pulse the `sample_valid_o` bit;
  - drop `adc_enable_o`;
  - go to RELEASE.
- RELEASE:
  - Holds `adc_enable_o`=0 for 2 cycles so the ADC returns to idle.
  - Then goes to SELECT if the pending mask is nonzero, otherwise to DONE.
- DONE: pulses `scan_done_o`, then returns to IDLE.
- `adc_channel_o` stays constant from SELECT through RELEASE.
- Tick generator:
  - Counts 0..SCAN_PERIOD-1 continuously while `continuous_i`=1 and is held at 0 otherwise.
  - A tick is issued at terminal count.
  - A tick while busy sets `overrun_o` and is dropped, not queued.
- Timeout:
  - A counter runs in WAIT_CLR and WAIT_RDY and resets on entry to SELECT.
  - Reaching TIMEOUT_CYCLES sets `timeout_o`. The FSM keeps waiting, because the ADC cannot be aborted mid-transaction.
- `clear_i` clears both sticky flags. A set event in the same cycle as `clear_i` wins.
- A `trigger_i` arriving in the same cycle as a tick in IDLE starts one scan only.
- Sample registers hold their value across scans. Channels absent from the mask are untouched.

## Timing
- Reset values:
  - all outputs 0;
  - sample_o = 0;
  - FSM in IDLE;
  - tick counter and timeout counter at 0.
- Cycle-level latency:
  - Trigger in cycle t puts the FSM in SELECT at t+1.
  - `adc_enable_o` and `adc_channel_o` are valid at t+2.
  - Ready seen high in cycle r puts the sample and `sample_valid_o` at r+1, with `adc_enable_o`=0 at r+1.
  - Between conversions `adc_enable_o` is low for at least 3 cycles.
  - `scan_done_o` is asserted 3 cycles after the last capture.
- All outputs are registered.
- Reset mid-scan: `adc_enable_o` drops immediately and the FSM returns to IDLE. The ADC block is reset by the same rst_ni.

## Structure
- A shared package `adc_pkg` holds:
  - FSM state encodings;
  - channel-index width (2);
  - sample width (16);
  - the default SCAN_PERIOD and TIMEOUT_CYCLES.
- One natural sub-module: `tick_gen` (period counter with enable and terminal-count pulse).
- Lowest-set-bit selection is inline combinational logic.

## Test plan
- Mask 4'b1111, trigger, ADC model returning 16'h1000+n for AINn → channels 0,1,2,3 converted in order; sample_o = 64'h1003_1002_1001_1000; four valid strobes; one scan_done_o.
- Mask 4'b1010, model keeps ready stale-high for 3 cycles after each request → only ch1 and ch3 converted (16'hABCD, 16'h1234); no capture of stale data; ch0 and ch2 slices unchanged.
- continuous_i=1, SCAN_PERIOD=100, conversion lasting 150 cycles → overrun_o=1 after the second tick; clear_i in the same cycle as the next overrun event → overrun_o stays 1.
- Mask 4'b0000, trigger → busy_o, adc_enable_o and scan_done_o stay 0 for 50 cycles.
- TIMEOUT_CYCLES=64, model never raises ready for 100 cycles, then raises it with 16'h7FFF → timeout_o=1 at cycle 64 of the wait; the sample is still latched; the scan completes.
- rst_ni low during WAIT_RDY of ch2 → all outputs 0 asynchronously; a new trigger after release restarts at ch0.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared definitions for the ADS1115 multi-channel scan sequencer.
package adc_pkg;

    localparam int unsigned ChanW            = 2;
    localparam int unsigned NumChan          = 4;
    localparam int unsigned SampleW          = 16;
    localparam int unsigned DefScanPeriod    = 27_000_000;
    localparam int unsigned DefTimeoutCycles = 2_700_000;

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StWaitClr,
        StWaitRdy,
        StRelease,
        StDone
    } scan_state_e;

endpackage

// File: rtl/tick_gen.sv
// Free-running period counter; pulses tick_o at terminal count while enabled.
module tick_gen #(
    parameter int unsigned PERIOD = 27_000_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned     CntW    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(PERIOD - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Count 0..PERIOD-1 while enabled, park at 0 otherwise.
    always_comb begin
        cnt_d = '0;
        if (en_i) begin
            cnt_d = (cnt_q == LastCnt) ? '0 : cnt_q + CntW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && (cnt_q == LastCnt);

endmodule

// File: rtl/adc_scan_scheduler.sv
// Walks the enabled channels of a 4-bit mask, runs one ADC conversion per
// channel through the enable/ready handshake and latches each result.
module adc_scan_scheduler
    import adc_pkg::*;
#(
    parameter int unsigned SCAN_PERIOD    = DefScanPeriod,
    parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        trigger_i,
    input  logic        continuous_i,
    input  logic [3:0]  channel_mask_i,
    input  logic        clear_i,
    output logic [1:0]  adc_channel_o,
    output logic        adc_enable_o,
    input  logic [15:0] adc_data_i,
    input  logic        adc_data_ready_i,
    output logic [63:0] sample_o,
    output logic [3:0]  sample_valid_o,
    output logic        busy_o,
    output logic        scan_done_o,
    output logic        overrun_o,
    output logic        timeout_o
);

    localparam int unsigned     TmoW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TmoW-1:0] TmoMax  = TmoW'(TIMEOUT_CYCLES);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

    scan_state_e                 state_q, state_d;
    logic [NumChan-1:0]          pend_q, pend_d;
    logic [ChanW-1:0]            chan_q, chan_d;
    logic                        en_q, en_d;
    logic [NumChan*SampleW-1:0]  sample_q, sample_d;
    logic [NumChan-1:0]          valid_q, valid_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        overrun_q, overrun_d;
    logic                        timeout_q, timeout_d;
    logic                        rel_q, rel_d;
    logic [TmoW-1:0]             tmo_cnt_q, tmo_cnt_d;
    logic [ChanW-1:0]            low_idx;
    logic                        tick;
    logic                        tmo_hit;

    tick_gen #(
        .PERIOD (SCAN_PERIOD)
    ) u_tick_gen (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (continuous_i),
        .tick_o (tick)
    );

    // Lowest set bit of the pending mask picks the next channel.
    always_comb begin
        low_idx = '0;
        for (int n = NumChan - 1; n >= 0; n--) begin
            if (pend_q[n]) begin
                low_idx = ChanW'(n);
            end
        end
    end

    // Scan sequencer next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        chan_d    = chan_q;
        en_d      = en_q;
        sample_d  = sample_q;
        valid_d   = '0;
        done_d    = 1'b0;
        rel_d     = rel_q;
        tmo_cnt_d = tmo_cnt_q;
        tmo_hit   = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Trigger and tick together still start only one scan.
                if ((trigger_i || tick) && (channel_mask_i != '0)) begin
                    pend_d    = channel_mask_i;
                    tmo_cnt_d = '0;
                    state_d   = StSelect;
                end
            end
            StSelect: begin
                chan_d          = low_idx;
                en_d            = 1'b1;
                pend_d[low_idx] = 1'b0;
                state_d         = StWaitClr;
            end
            StWaitClr, StWaitRdy: begin
                if (tmo_cnt_q != TmoMax) begin
                    tmo_cnt_d = tmo_cnt_q + TmoW'(1);
                    tmo_hit   = (tmo_cnt_q == TmoLast);
                end
                if (state_q == StWaitClr) begin
                    // Ready low means the ADC took the request; older ready is stale.
                    if (!adc_data_ready_i) begin
                        state_d = StWaitRdy;
                    end
                end else if (adc_data_ready_i) begin
                    for (int n = 0; n < NumChan; n++) begin
                        if (chan_q == ChanW'(n)) begin
                            sample_d[n*SampleW +: SampleW] = adc_data_i;
                        end
                    end
                    valid_d[chan_q] = 1'b1;
                    en_d            = 1'b0;
                    rel_d           = 1'b0;
                    state_d         = StRelease;
                end
            end
            StRelease: begin
                // Two idle-enable cycles let the ADC return to idle.
                if (rel_q) begin
                    if (pend_q != '0) begin
                        tmo_cnt_d = '0;
                        state_d   = StSelect;
                    end else begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end
                end else begin
                    rel_d = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    // Sticky flags: a set event beats a simultaneous clear.
    always_comb begin
        overrun_d = clear_i ? 1'b0 : overrun_q;
        timeout_d = clear_i ? 1'b0 : timeout_q;
        if (tick && (state_q != StIdle)) begin
            overrun_d = 1'b1;
        end
        if (tmo_hit) begin
            timeout_d = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            pend_q    <= '0;
            chan_q    <= '0;
            en_q      <= 1'b0;
            sample_q  <= '0;
            valid_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            rel_q     <= 1'b0;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            chan_q    <= chan_d;
            en_q      <= en_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
            rel_q     <= rel_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign adc_channel_o  = chan_q;
    assign adc_enable_o   = en_q;
    assign sample_o       = sample_q;
    assign sample_valid_o = valid_q;
    assign busy_o         = busy_q;
    assign scan_done_o    = done_q;
    assign overrun_o      = overrun_q;
    assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Directed bench for adc_scan_scheduler with a behavioural ADC responder.
module tb_adc_scan_scheduler;

    logic        clk;
    logic        rst_n;
    logic        trigger;
    logic        continuous;
    logic [3:0]  mask;
    logic        clear;
    logic [1:0]  adc_ch;
    logic        adc_en;
    logic [15:0] adc_data;
    logic        adc_ready;
    logic [63:0] sample;
    logic [3:0]  sample_valid;
    logic        busy;
    logic        scan_done;
    logic        overrun;
    logic        timeout;

    int n_checks = 0;
    int n_fail   = 0;

    // ADC model controls and monitor accumulators.
    logic [15:0] data_tbl [4];
    int          stale_cycles;
    int          conv_cycles;
    int          valid_total = 0;
    int          done_total  = 0;
    int          conv_log [$];

    adc_scan_scheduler #(
        .SCAN_PERIOD    (100),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .trigger_i        (trigger),
        .continuous_i     (continuous),
        .channel_mask_i   (mask),
        .clear_i          (clear),
        .adc_channel_o    (adc_ch),
        .adc_enable_o     (adc_en),
        .adc_data_i       (adc_data),
        .adc_data_ready_i (adc_ready),
        .sample_o         (sample),
        .sample_valid_o   (sample_valid),
        .busy_o           (busy),
        .scan_done_o      (scan_done),
        .overrun_o        (overrun),
        .timeout_o        (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (!scan_done && k < budget) begin
            step(1);
            k++;
        end
        check_eq({tag, "_done_seen"}, 64'(scan_done), 64'd1);
        step(1);
    endtask

    // Order of converted channels since index 'from', packed two bits each.
    function automatic logic [63:0] conv_order(input int from);
        logic [63:0] ord;
        ord = '0;
        for (int i = from; i < conv_log.size(); i++) begin
            ord = (ord << 2) | 64'(conv_log[i]);
        end
        return ord;
    endfunction

    // ADC responder: holds ready stale-high for stale_cycles after a request,
    // then low for conv_cycles, then high with the channel's data until the
    // next request. Also tallies strobes, done pulses and request order.
    initial begin
        int   m_state;
        int   m_cnt;
        logic prev_en;
        m_state   = 0;
        m_cnt     = 0;
        prev_en   = 1'b0;
        adc_ready = 1'b0;
        adc_data  = '0;
        forever begin
            @(negedge clk);
            valid_total += $countones(sample_valid);
            if (scan_done) done_total++;
            if (adc_en && !prev_en) conv_log.push_back(int'(adc_ch));
            prev_en = adc_en;
            if (!rst_n) begin
                m_state   = 0;
                adc_ready = 1'b0;
                adc_data  = '0;
            end else begin
                case (m_state)
                    0: if (adc_en) begin
                        m_cnt   = 0;
                        m_state = 1;
                    end
                    1: if (m_cnt >= stale_cycles) begin
                        adc_ready = 1'b0;
                        m_cnt     = 0;
                        m_state   = 2;
                    end else begin
                        m_cnt++;
                    end
                    2: begin
                        m_cnt++;
                        if (m_cnt >= conv_cycles) begin
                            adc_ready = 1'b1;
                            adc_data  = data_tbl[adc_ch];
                            m_state   = 3;
                        end
                    end
                    default: if (!adc_en) m_state = 0;
                endcase
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          v0;
        int          d0;
        int          c0;
        int          k;
        logic [63:0] acc;

        rst_n        = 1'b0;
        trigger      = 1'b0;
        continuous   = 1'b0;
        mask         = 4'h0;
        clear        = 1'b0;
        stale_cycles = 0;
        conv_cycles  = 5;
        for (int n = 0; n < 4; n++) data_tbl[n] = 16'h1000 + 16'(n);

        // Reset state.
        step(3);
        check_eq("rst_sample", sample, 64'h0);
        check_eq("rst_busy", 64'(busy), 64'h0);
        check_eq("rst_en", 64'(adc_en), 64'h0);
        check_eq("rst_ch", 64'(adc_ch), 64'h0);
        check_eq("rst_flags", 64'({scan_done, overrun, timeout, sample_valid}), 64'h0);
        rst_n = 1'b1;
        step(2);

        // Full mask scan, ascending order.
        mask = 4'b1111;
        v0 = valid_total; d0 = done_total; c0 = conv_log.size();
        trigger = 1'b1;
        step(1);
        trigger = 1'b0;
        check_eq("t1_busy_t1", 64'(busy), 64'h1);
        check_eq("t1_en_t1", 64'(adc_en), 64'h0);
        step(1);
        check_eq("t1_en_t2", 64'(adc_en), 64'h1);
        check_eq("t1_ch_t2", 64'(adc_ch), 64'h0);
        wait_done("t1", 400);
        check_eq("t1_sample", sample, 64'h1003_1002_1001_1000);
        check_eq("t1_valids", 64'(valid_total - v0), 64'd4);
        check_eq("t1_dones", 64'(done_total - d0), 64'd1);
        check_eq("t1_order", conv_order(c0), 64'h1B);
        check_eq("t1_idle", 64'(busy), 64'h0);

        // Sparse mask with stale-high ready after each request.
        mask = 4'b1010;
        data_tbl[1] = 16'hABCD;
        data_tbl[3] = 16'h1234;
        stale_cycles = 3;
        conv_cycles  = 4;
        v0 = valid_total; d0 = done_total; c0 = conv_log.size();
        trigger = 1'b1;
        step(1);
        trigger = 1'b0;
        wait_done("t2", 400);
        check_eq("t2_sample", sample, 64'h1234_1002_ABCD_1000);
        check_eq("t2_valids", 64'(valid_total - v0), 64'd2);
        check_eq("t2_dones", 64'(done_total - d0), 64'd1);
        check_eq("t2_order", conv_order(c0), 64'h07);

        // Continuous mode, conversion longer than the scan period.
        mask = 4'b0001;
        stale_cycles = 0;
        conv_cycles  = 150;
        continuous   = 1'b1;
        step(199);
        check_eq("t3_ovr_pre", 64'(overrun), 64'h0);
        step(1);
        check_eq("t3_ovr_set", 64'(overrun), 64'h1);
        step(50);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check_eq("t3_ovr_clr", 64'(overrun), 64'h0);
        check_eq("t3_tmo_clr", 64'(timeout), 64'h0);
        step(148);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check_eq("t3_ovr_race", 64'(overrun), 64'h1);
        continuous = 1'b0;
        wait_done("t3", 400);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check_eq("t3_flags_off", 64'({overrun, timeout}), 64'h0);

        // Empty mask starts nothing.
        mask = 4'b0000;
        d0 = done_total;
        trigger = 1'b1;
        step(1);
        trigger = 1'b0;
        acc = '0;
        for (int i = 0; i < 50; i++) begin
            acc = acc | 64'({busy, adc_en, scan_done});
            step(1);
        end
        check_eq("t4_quiet", acc, 64'h0);
        check_eq("t4_dones", 64'(done_total - d0), 64'd0);

        // Timeout while the ADC stalls; the sample still lands.
        mask = 4'b0100;
        data_tbl[2] = 16'h7FFF;
        conv_cycles = 100;
        trigger = 1'b1;
        step(1);
        trigger = 1'b0;
        step(64);
        check_eq("t5_tmo_pre", 64'(timeout), 64'h0);
        step(1);
        check_eq("t5_tmo_set", 64'(timeout), 64'h1);
        wait_done("t5", 400);
        check_eq("t5_sample", sample, 64'h1234_7FFF_ABCD_1000);
        check_eq("t5_tmo_hold", 64'(timeout), 64'h1);

        // Reset in the middle of channel 2, then a clean restart.
        mask = 4'b1111;
        for (int n = 0; n < 4; n++) data_tbl[n] = 16'h2000 + 16'(n);
        conv_cycles = 20;
        trigger = 1'b1;
        step(1);
        trigger = 1'b0;
        k = 0;
        while (!(adc_en && adc_ch == 2'd2) && k < 400) begin
            step(1);
            k++;
        end
        check_eq("t6_reach_ch2", 64'(adc_en && adc_ch == 2'd2), 64'h1);
        step(5);
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_en", 64'(adc_en), 64'h0);
        check_eq("t6_rst_state", 64'({busy, adc_ch, timeout, scan_done}), 64'h0);
        check_eq("t6_rst_sample", sample, 64'h0);
        step(2);
        rst_n = 1'b1;
        step(2);
        c0 = conv_log.size();
        trigger = 1'b1;
        step(1);
        trigger = 1'b0;
        step(1);
        check_eq("t6_restart_en", 64'(adc_en), 64'h1);
        check_eq("t6_restart_ch", 64'(adc_ch), 64'h0);
        wait_done("t6", 400);
        check_eq("t6_sample", sample, 64'h2003_2002_2001_2000);
        check_eq("t6_order", conv_order(c0), 64'h1B);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
